// File: rtl/mipi_tx_pkg.sv
// Shared definitions for the MIPI CSI-2 transmit packet generator.
// Contents: FSM state enum, CRC constants, data-type codes, and the header ECC
// and byte-wise CRC-16 helper functions.
package mipi_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHdr,
        StPay,
        StCrc,
        StEnd,
        StGap
    } state_e;

    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    // CSI-2 header ECC over {wc[15:0], di[7:0]}. Each mask selects the data
    // bits that feed one parity bit. Bits [7:6] of the result are always 0.
    function automatic logic [7:0] csi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return {2'b00, p};
    endfunction

    // Reflected CRC-16/CCITT, one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mipi_tx_crc16.sv
// Byte-wide CRC-16 register for the CSI-2 packet footer.
// Ports: clk/rst (sync, active-high), init loads CRC_INIT, en folds data into
// the running CRC, crc is the current register value.
module mipi_tx_crc16
    import mipi_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc16_byte(crc_q, data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mipi_tx_pkt_gen.sv
// CSI-2 packet generator driving a single byte lane of the D-PHY TX HS
// interface in the byte-clock domain.
// Ports: pkt_start/pkt_di/pkt_wc request a packet (pkt_busy while in flight);
// pay_data/pay_valid/pay_ready supply the payload; hs_req/hs_ready/hs_data are
// the PHY HS handshake; underrun_err is sticky; pkt_done pulses after the last
// byte is accepted.
//
// hs_data_q always holds the byte currently offered to the PHY. The state says
// which byte is loaded next when the PHY accepts the current one, so payload
// is consumed on the same edge that the previous byte is accepted.
module mipi_tx_pkt_gen
    import mipi_tx_pkg::*;
#(
    parameter logic [5:0]  SHORT_DT_MAX = 6'h0F,
    parameter int unsigned PKT_GAP      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_start,
    input  logic [7:0]  pkt_di,
    input  logic [15:0] pkt_wc,
    output logic        pkt_busy,
    input  logic [7:0]  pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic        hs_req,
    input  logic        hs_ready,
    output logic [7:0]  hs_data,
    output logic        underrun_err,
    output logic        pkt_done
);

    localparam int unsigned GapW = (PKT_GAP > 1) ? $clog2(PKT_GAP) : 1;

    state_e            state_q, state_d;
    logic [7:0]        di_q, di_d;
    logic [15:0]       wc_q, wc_d;
    logic [7:0]        ecc_q, ecc_d;
    logic              short_q, short_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              busy_q, busy_d;
    logic              hs_req_q, hs_req_d;
    logic [7:0]        hs_data_q, hs_data_d;
    logic              underrun_q, underrun_d;
    logic              done_q, done_d;

    logic              crc_init;
    logic              crc_en;
    logic [7:0]        crc_byte;
    logic [15:0]       crc_val;

    mipi_tx_crc16 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (crc_byte),
        .crc  (crc_val)
    );

    // Underrun slots are transmitted and checksummed as zero.
    assign crc_byte = pay_valid ? pay_data : 8'h00;

    always_comb begin
        state_d    = state_q;
        di_d       = di_q;
        wc_d       = wc_q;
        ecc_d      = ecc_q;
        short_d    = short_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        hs_req_d   = hs_req_q;
        hs_data_d  = hs_data_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        crc_init   = 1'b0;
        crc_en     = 1'b0;
        pay_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pkt_start) begin
                    state_d   = StReq;
                    di_d      = pkt_di;
                    wc_d      = pkt_wc;
                    ecc_d     = csi_ecc({pkt_wc, pkt_di});
                    short_d   = (pkt_di[5:0] <= SHORT_DT_MAX);
                    busy_d    = 1'b1;
                    hs_req_d  = 1'b1;
                    hs_data_d = pkt_di;
                    crc_init  = 1'b1;
                end
            end
            StReq: begin
                if (hs_ready) begin
                    hs_data_d = wc_q[7:0];
                    idx_d     = 2'd2;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                if (hs_ready) begin
                    if (idx_q == 2'd2) begin
                        hs_data_d = wc_q[15:8];
                        idx_d     = 2'd3;
                    end else begin
                        hs_data_d = ecc_q;
                        if (short_q) begin
                            state_d = StEnd;
                        end else if (wc_q == 16'h0000) begin
                            state_d = StCrc;
                            idx_d   = 2'd0;
                        end else begin
                            state_d = StPay;
                            cnt_d   = wc_q;
                        end
                    end
                end
            end
            StPay: begin
                // The PHY cannot pause HS, so a missing byte becomes a zero.
                pay_ready = hs_ready;
                if (hs_ready) begin
                    crc_en    = 1'b1;
                    hs_data_d = crc_byte;
                    if (!pay_valid) begin
                        underrun_d = 1'b1;
                    end
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = StCrc;
                        idx_d   = 2'd0;
                    end
                end
            end
            StCrc: begin
                if (hs_ready) begin
                    if (idx_q == 2'd0) begin
                        hs_data_d = crc_val[7:0];
                        idx_d     = 2'd1;
                    end else begin
                        hs_data_d = crc_val[15:8];
                        state_d   = StEnd;
                    end
                end
            end
            StEnd: begin
                // Final byte is on the bus; finish once the PHY takes it.
                if (hs_ready) begin
                    done_d   = 1'b1;
                    hs_req_d = 1'b0;
                    gap_d    = '0;
                    state_d  = StGap;
                end
            end
            StGap: begin
                // Gap timing is free-running; hs_ready is meaningless with hs_req low.
                if (gap_q == GapW'(PKT_GAP - 1)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            di_q       <= 8'h00;
            wc_q       <= 16'h0000;
            ecc_q      <= 8'h00;
            short_q    <= 1'b0;
            idx_q      <= 2'd0;
            cnt_q      <= 16'h0000;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            hs_req_q   <= 1'b0;
            hs_data_q  <= 8'h00;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            di_q       <= di_d;
            wc_q       <= wc_d;
            ecc_q      <= ecc_d;
            short_q    <= short_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            busy_q     <= busy_d;
            hs_req_q   <= hs_req_d;
            hs_data_q  <= hs_data_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

    assign pkt_busy     = busy_q;
    assign hs_req       = hs_req_q;
    assign hs_data      = hs_data_q;
    assign underrun_err = underrun_q;
    assign pkt_done     = done_q;

endmodule

// File: tb/tb_mipi_tx_pkt_gen.sv
// Self-checking bench for mipi_tx_pkt_gen. Expected byte streams are built
// from an independent ECC/CRC model into a queue; a negedge monitor pops and
// compares every byte the PHY accepts.
module tb_mipi_tx_pkt_gen;

    localparam logic [5:0] SHORT_MAX = 6'h0F;
    localparam int         GAP       = 4;

    // Parity-bit syndrome contributed by each header data bit D0..D23.
    localparam logic [5:0] ECC_SYN [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_start;
    logic [7:0]  pkt_di;
    logic [15:0] pkt_wc;
    logic        pkt_busy;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic        hs_req;
    logic        hs_ready;
    logic [7:0]  hs_data;
    logic        underrun_err;
    logic        pkt_done;

    int          checks = 0;
    int          passed = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  pay_b [$];
    bit          pay_v [$];
    logic [7:0]  mon_exp;

    always #5 clk = ~clk;

    mipi_tx_pkt_gen dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_start    (pkt_start),
        .pkt_di       (pkt_di),
        .pkt_wc       (pkt_wc),
        .pkt_busy     (pkt_busy),
        .pay_data     (pay_data),
        .pay_valid    (pay_valid),
        .pay_ready    (pay_ready),
        .hs_req       (hs_req),
        .hs_ready     (hs_ready),
        .hs_data      (hs_data),
        .underrun_err (underrun_err),
        .pkt_done     (pkt_done)
    );

    function automatic logic [7:0] ref_ecc(input logic [23:0] d);
        logic [5:0] p = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) p = p ^ ECC_SYN[i];
        end
        return {2'b00, p};
    endfunction

    function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c = crc;
        logic        fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[15:1]};
            if (fb) begin
                c[15] = ~c[15];
                c[10] = ~c[10];
                c[3]  = ~c[3];
            end
        end
        return c;
    endfunction

    // Every byte the PHY takes must be the next one the model predicted.
    always @(negedge clk) begin
        if (!rst && hs_req && hs_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL hs_byte: got %02h, required no byte (none pending)", hs_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (hs_data !== mon_exp)
                    $display("FAIL hs_byte: got %02h, required %02h", hs_data, mon_exp);
                else
                    passed++;
            end
        end
    end

    task automatic push_expected(input logic [7:0] di, input logic [15:0] wc);
        logic [15:0] c = 16'hFFFF;
        logic [7:0]  b;
        exp_q.push_back(di);
        exp_q.push_back(wc[7:0]);
        exp_q.push_back(wc[15:8]);
        exp_q.push_back(ref_ecc({wc, di}));
        if (di[5:0] > SHORT_MAX) begin
            for (int i = 0; i < int'(wc); i++) begin
                b = pay_v[i] ? pay_b[i] : 8'h00;
                exp_q.push_back(b);
                c = ref_crc(c, b);
            end
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endtask

    task automatic set_payload(input int k);
        pay_data  = (k < pay_b.size()) ? pay_b[k] : 8'h00;
        pay_valid = (k < pay_b.size()) ? pay_v[k] : 1'b0;
    endtask

    // Runs one packet to completion, then checks the done pulse and gap.
    task automatic run_pkt(input logic [7:0] di, input logic [15:0] wc, input int stall,
                           input bit poke, input bit exp_unr);
        int k = 0;
        int cyc = 0;
        int n = 0;
        bit done = 0;
        bit was_ready;
        int exp_k;
        push_expected(di, wc);
        exp_k = (di[5:0] > SHORT_MAX) ? int'(wc) : 0;
        pkt_di    = di;
        pkt_wc    = wc;
        pkt_start = 1'b1;
        @(posedge clk); #1;
        pkt_start = 1'b0;
        checks++;
        if ({pkt_busy, hs_req, hs_data} !== {1'b1, 1'b1, di})
            $display("FAIL start: got busy/req/data %b/%b/%02h, required 1/1/%02h",
                     pkt_busy, hs_req, hs_data, di);
        else
            passed++;
        while (!done && cyc < 3000) begin
            hs_ready  = (cyc >= stall);
            pkt_start = poke && (cyc == 2);
            if (pkt_start) pkt_di = 8'h01;
            set_payload(k);
            @(negedge clk);
            if (cyc < stall) begin
                checks++;
                if ({hs_req, hs_data} !== {1'b1, di})
                    $display("FAIL stall_hold: got req/data %b/%02h, required 1/%02h",
                             hs_req, hs_data, di);
                else
                    passed++;
            end
            was_ready = pay_ready;
            @(posedge clk); #1;
            pkt_start = 1'b0;
            if (was_ready) k++;
            if (pkt_done) done = 1;
            cyc++;
        end
        hs_ready = 1'b1;
        checks++;
        if (!done) $display("FAIL pkt_done_timeout: got no pulse, required pulse");
        else passed++;
        checks++;
        if ({hs_req, pkt_busy} !== 2'b01)
            $display("FAIL done_cycle: got req/busy %b/%b, required 0/1", hs_req, pkt_busy);
        else
            passed++;
        while (pkt_busy === 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                checks++;
                if (pkt_done !== 1'b0) $display("FAIL done_pulse: got %b, required 0", pkt_done);
                else passed++;
            end
        end
        checks++;
        if (n !== GAP) $display("FAIL gap_len: got %0d, required %0d", n, GAP);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL all_bytes: got %0d left, required 0", exp_q.size());
        else passed++;
        checks++;
        if (k != exp_k) $display("FAIL pay_consumed: got %0d, required %0d", k, exp_k);
        else passed++;
        checks++;
        if (underrun_err !== exp_unr)
            $display("FAIL underrun: got %b, required %b", underrun_err, exp_unr);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pkt_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pkt_busy, pay_ready, hs_req, underrun_err, pkt_done, hs_data} !== 13'h0)
            $display("FAIL reset_vals: got %b%b%b%b%b/%02h, required 00000/00", pkt_busy,
                     pay_ready, hs_req, underrun_err, pkt_done, hs_data);
        else
            passed++;
        rst = 1'b0;
        pkt_start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({pkt_busy, hs_req} !== 2'b00)
            $display("FAIL reset_idle: got busy/req %b/%b, required 0/0", pkt_busy, hs_req);
        else
            passed++;
    endtask

    task automatic test_short_fs();
        pay_b.delete(); pay_v.delete();
        run_pkt(8'h00, 16'h0000, 0, 0, 0);
        run_pkt(8'h41, 16'h1234, 0, 0, 0);
    endtask

    task automatic test_long_raw8();
        pay_b = '{8'h01, 8'h02, 8'h03, 8'h04};
        pay_v = '{1, 1, 1, 1};
        run_pkt(8'h2A, 16'd4, 0, 0, 0);
    endtask

    task automatic test_long_wc0();
        pay_b.delete(); pay_v.delete();
        run_pkt(8'h2B, 16'd0, 0, 0, 0);
    endtask

    task automatic test_start_latency();
        pay_b = '{8'h5A, 8'hA5};
        pay_v = '{1, 1};
        run_pkt(8'h6A, 16'd2, 5, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pkt_busy, hs_req} !== 2'b00)
            $display("FAIL busy_ignore: got busy/req %b/%b, required 0/0", pkt_busy, hs_req);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        pay_b.delete(); pay_v.delete();
        for (int i = 0; i < 16; i++) begin
            pay_b.push_back(8'($urandom_range(0, 255)));
            pay_v.push_back(1'b1);
        end
        run_pkt(8'hAA, 16'd16, 0, 0, 0);
        pay_b.delete(); pay_v.delete();
        run_pkt(8'h01, 16'h00FF, 0, 0, 0);
    endtask

    task automatic test_underrun();
        pay_b = '{8'hAA, 8'h77, 8'hBB};
        pay_v = '{1, 0, 1};
        run_pkt(8'h2A, 16'd3, 0, 0, 1);
        pay_b.delete(); pay_v.delete();
        run_pkt(8'h02, 16'h0000, 0, 0, 1);
    endtask

    task automatic test_rst_mid();
        int k = 0;
        int cyc = 0;
        bit was_ready;
        pay_b.delete(); pay_v.delete();
        for (int i = 0; i < 8; i++) begin
            pay_b.push_back(8'(8'h10 + i));
            pay_v.push_back(1'b1);
        end
        push_expected(8'h2A, 16'd8);
        pkt_di = 8'h2A; pkt_wc = 16'd8; pkt_start = 1'b1;
        @(posedge clk); #1;
        pkt_start = 1'b0;
        while (k < 2 && cyc < 100) begin
            set_payload(k);
            @(negedge clk);
            was_ready = pay_ready;
            @(posedge clk); #1;
            if (was_ready) k++;
            cyc++;
        end
        checks++;
        if (k != 2) $display("FAIL rst_reach: got %0d bytes, required 2", k);
        else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({hs_req, pkt_busy, underrun_err} !== 3'b000)
            $display("FAIL rst_mid: got req/busy/unr %b/%b/%b, required 0/0/0",
                     hs_req, pkt_busy, underrun_err);
        else
            passed++;
        exp_q.delete();
        rst = 1'b0;
        pay_b.delete(); pay_v.delete();
        run_pkt(8'hC3, 16'hBEEF, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; pkt_start = 1'b0; pkt_di = 8'h00; pkt_wc = 16'h0000;
        pay_data = 8'h00; pay_valid = 1'b0; hs_ready = 1'b1;
        test_reset();
        test_short_fs();
        test_long_raw8();
        test_long_wc0();
        test_start_latency();
        test_back_to_back();
        test_underrun();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
